rr_arbiter_n: RTL and testbench

N-way round-robin arbiter with a registered one-hot grant and optional per-requester grant locking (multi-cycle ownership). A configurable hold limit forces release so no requester can starve the others. It is the parametrised successor of the team's 2-way alternating arbiter and sits in front of any shared resource (bus, memory port, FIFO write side) with up to N masters.

---
 rtl/rr_arb_pkg.sv | 28 ++
 rtl/rr_prio_pick.sv | 42 ++++
 rtl/rr_arbiter_n.sv | 142 ++++++++++++++
 tb/tb_rr_arbiter_n.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the N-way round-robin arbiter.
//
// Contents:
//   arb_state_e    - arbiter FSM state (IDLE: no owner, GRANT: owner = gnt_id)
//   MAX_N          - largest supported requester count
//   onehot_to_idx  - binary index of a one-hot vector (zero-extended to MAX_N)
package rr_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    localparam int MAX_N = 32;

    // OR-reduction encoder: exact for one-hot inputs, returns 0 for all-zero.
    function automatic logic [4:0] onehot_to_idx(input logic [MAX_N-1:0] oh);
        logic [4:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_N; i++) begin
            if (oh[i]) begin
                idx = idx | 5'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_prio_pick.sv
// Combinational round-robin priority pick.
//
// Returns the first requester at or after (last+1) mod N, scanning upward with
// wrap-around, as a one-hot vector (all zero when nothing is requesting).
//
// Ports:
//   req  [N-1:0]   request vector
//   last [IDW-1:0] index of the most recent owner (lowest priority)
//   pick [N-1:0]   one-hot winner, or zero
//   any            |req
module rr_prio_pick #(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] last,
    output logic [N-1:0]   pick,
    output logic           any
);

    logic [IDW:0]     start;
    logic [2*N-1:0]   dbl;
    logic [2*N-1:0]   rot_dbl;
    logic [2*N-1:0]   back_dbl;
    logic [N-1:0]     rot;
    logic [N-1:0]     rot_pick;

    // Rotate the request vector right so the highest-priority slot lands at
    // bit 0, isolate the lowest set bit, then rotate the winner back. Both
    // rotates use a doubled vector so a plain shift performs the wrap.
    always_comb begin
        start    = ({1'b0, last} == (IDW+1)'(N-1)) ? '0 : {1'b0, last} + (IDW+1)'(1);
        dbl      = {req, req};
        rot_dbl  = dbl >> start;
        rot      = rot_dbl[N-1:0];
        rot_pick = rot & (~rot + N'(1));
        back_dbl = {rot_pick, rot_pick} << start;
        pick     = back_dbl[2*N-1:N];
        any      = |req;
    end

endmodule

// File: rtl/rr_arbiter_n.sv
// N-way round-robin arbiter with registered one-hot grant, per-requester grant
// locking and a hold limit that forces release so nobody starves.
//
// Handshake: req is a level request. A requester owns the resource in every
// cycle its gnt bit is high; gnt reflects req/lock sampled on the previous
// edge, so an owner that drops req still sees gnt for that cycle and loses it
// on the next edge. With lock high the owner keeps the grant while req stays
// high, until MAX_HOLD consecutive grant cycles have elapsed (0 = unlimited).
//
// Ports:
//   clk       clock, rising edge
//   rst       synchronous active-high reset
//   req       [N-1:0] requests
//   lock      [N-1:0] grant lock per requester (only the owner's bit matters)
//   gnt       [N-1:0] registered one-hot grant, zero when idle
//   gnt_vld   |gnt
//   gnt_id    [IDW-1:0] index of current owner, holds last value when idle
//   preempt   high in the last grant cycle when only the hold limit ends it
//   dbg_state FSM state
module rr_arbiter_n
    import rr_arb_pkg::*;
#(
    parameter int N        = 4,    // 2..32
    parameter int MAX_HOLD = 16,
    parameter int IDW      = $clog2(N),
    parameter int HCW      = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic [N-1:0]    lock,
    output logic [N-1:0]    gnt,
    output logic            gnt_vld,
    output logic [IDW-1:0]  gnt_id,
    output logic            preempt,
    output arb_state_e      dbg_state
);

    localparam logic [HCW-1:0] HOLD_LAST = HCW'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

    arb_state_e     state, state_n;
    logic [N-1:0]   gnt_n;
    logic [IDW-1:0] gnt_id_n;
    logic [IDW-1:0] last, last_n;
    logic [HCW-1:0] hold_cnt, hold_cnt_n;

    logic           own_req, own_lock;
    logic           rel_drop, rel_unlk, rel_to, rel;
    logic [IDW-1:0] pick_last;
    logic [N-1:0]   pick;
    logic           any;
    logic [MAX_N-1:0] pick_ext;
    logic [IDW-1:0] pick_idx;

    // Release conditions for the current owner.
    always_comb begin
        own_req  = req[gnt_id];
        own_lock = lock[gnt_id];
        rel_drop = !own_req;
        rel_unlk = !own_lock;
        rel_to   = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
        rel      = rel_drop | rel_unlk | rel_to;
    end

    // On release the pointer moves to the owner in the same edge, so the
    // re-arbitration already treats the outgoing owner as lowest priority.
    assign pick_last = (state == GRANT && rel) ? gnt_id : last;

    rr_prio_pick #(
        .N   (N),
        .IDW (IDW)
    ) u_pick (
        .req  (req),
        .last (pick_last),
        .pick (pick),
        .any  (any)
    );

    always_comb begin
        pick_ext          = '0;
        pick_ext[N-1:0]   = pick;
        pick_idx          = IDW'(onehot_to_idx(pick_ext));
    end

    always_comb begin
        state_n    = state;
        gnt_n      = gnt;
        gnt_id_n   = gnt_id;
        last_n     = last;
        hold_cnt_n = hold_cnt;
        case (state)
            IDLE: begin
                if (any) begin
                    state_n    = GRANT;
                    gnt_n      = pick;
                    gnt_id_n   = pick_idx;
                    hold_cnt_n = '0;
                end
            end
            GRANT: begin
                if (!rel) begin
                    hold_cnt_n = hold_cnt + HCW'(1);
                end else begin
                    last_n     = gnt_id;
                    hold_cnt_n = '0;
                    if (any) begin
                        gnt_n    = pick;
                        gnt_id_n = pick_idx;
                    end else begin
                        state_n  = IDLE;
                        gnt_n    = '0;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                gnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= '0;
            gnt_id   <= '0;
            last     <= IDW'(N - 1);
            hold_cnt <= '0;
        end else begin
            state    <= state_n;
            gnt      <= gnt_n;
            gnt_id   <= gnt_id_n;
            last     <= last_n;
            hold_cnt <= hold_cnt_n;
        end
    end

    assign gnt_vld   = |gnt;
    assign preempt   = (state == GRANT) && rel_to && own_req && own_lock;
    assign dbg_state = state;

endmodule

// File: tb/tb_rr_arbiter_n.sv
module tb_rr_arbiter_n;
  import rr_arb_pkg::*;

  localparam int N  = 4;
  localparam int EW = 4 + 2 + 1;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  logic [N-1:0] req;
  logic [N-1:0] lock;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // DUT a: MAX_HOLD=4, DUT b: MAX_HOLD=0 (unlimited); same stimulus.
  logic [N-1:0] gnt_a, gnt_b;
  logic         vld_a, vld_b;
  logic [1:0]   id_a, id_b;
  logic         pre_a, pre_b;
  arb_state_e   st_a, st_b;

  rr_arbiter_n #(.N(N), .MAX_HOLD(4)) dut (
    .clk(clk), .rst(rst), .req(req), .lock(lock),
    .gnt(gnt_a), .gnt_vld(vld_a), .gnt_id(id_a), .preempt(pre_a), .dbg_state(st_a)
  );

  rr_arbiter_n #(.N(N), .MAX_HOLD(0)) dut0 (
    .clk(clk), .rst(rst), .req(req), .lock(lock),
    .gnt(gnt_b), .gnt_vld(vld_b), .gnt_id(id_b), .preempt(pre_b), .dbg_state(st_b)
  );

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;
  int step_no = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    assert (obs === exp_v) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s step %0d: got %0h expected %0h", tag, step_no, obs, exp_v);
    end
  endtask

  task automatic check_out(input bit sel);
    logic [EW-1:0] e;
    logic [N-1:0]  eg;
    logic [1:0]    ei;
    logic          ep;
    logic [N-1:0]  g;
    logic          v;
    logic [1:0]    id;
    logic          p;
    arb_state_e    st;
    arb_state_e    est;
    e  = exp_q.pop_front();
    eg = e[6:3];
    ei = e[2:1];
    ep = e[0];
    if (sel) begin
      g = gnt_b; v = vld_b; id = id_b; p = pre_b; st = st_b;
    end else begin
      g = gnt_a; v = vld_a; id = id_a; p = pre_a; st = st_a;
    end
    est = (eg != '0) ? GRANT : IDLE;
    chk("gnt",       32'(g),  32'(eg));
    chk("gnt_vld",   32'(v),  32'(|eg));
    chk("gnt_id",    32'(id), 32'(ei));
    chk("preempt",   32'(p),  32'(ep));
    chk("state",     32'(st), 32'(est));
    chk("onehot0",   32'($onehot0(g)), 32'(1));
    chk("gnt_at_id", 32'(g[id]), 32'(v));
  endtask

  // ---------------- driver ----------------
  // Drive inputs for one cycle and check the outputs visible in that cycle:
  // registered gnt/gnt_id from the previous edge, preempt from current inputs.
  task automatic step(input bit sel, input logic r, input logic [N-1:0] rq,
                      input logic [N-1:0] lk, input logic [N-1:0] eg,
                      input logic [1:0] ei, input logic ep);
    @(negedge clk);
    step_no++;
    rst  = r;
    req  = rq;
    lock = lk;
    exp_q.push_back({eg, ei, ep});
    #1;
    check_out(sel);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst  = 1'b1;
    req  = 4'b1111;
    lock = 4'b0000;

    // 1. reset, then plain rotation
    step(0, 1, 4'b1111, 4'b0000, 4'b0000, 2'd0, 0);
    step(0, 0, 4'b1111, 4'b0000, 4'b0000, 2'd0, 0);
    step(0, 0, 4'b1111, 4'b0000, 4'b0001, 2'd0, 0);
    step(0, 0, 4'b1111, 4'b0000, 4'b0010, 2'd1, 0);
    step(0, 0, 4'b1111, 4'b0000, 4'b0100, 2'd2, 0);
    step(0, 0, 4'b1111, 4'b0000, 4'b1000, 2'd3, 0);

    // 2. locked owner 0 times out after 4 cycles, then 2 once, then 0
    step(0, 0, 4'b0101, 4'b0001, 4'b0001, 2'd0, 0);
    step(0, 0, 4'b0101, 4'b0001, 4'b0001, 2'd0, 0);
    step(0, 0, 4'b0101, 4'b0001, 4'b0001, 2'd0, 0);
    step(0, 0, 4'b0101, 4'b0001, 4'b0001, 2'd0, 1);
    step(0, 0, 4'b0101, 4'b0001, 4'b0100, 2'd2, 0);

    // 3. sole locked requester 1: continuous grant, preempt every 4th cycle
    step(0, 0, 4'b0010, 4'b0010, 4'b0001, 2'd0, 0);
    for (int k = 0; k < 2; k++) begin
      step(0, 0, 4'b0010, 4'b0010, 4'b0010, 2'd1, 0);
      step(0, 0, 4'b0010, 4'b0010, 4'b0010, 2'd1, 0);
      step(0, 0, 4'b0010, 4'b0010, 4'b0010, 2'd1, 0);
      step(0, 0, 4'b0010, 4'b0010, 4'b0010, 2'd1, 1);
    end

    // 4. owner 0 drops req in its 2nd grant cycle
    step(0, 0, 4'b0001, 4'b0001, 4'b0010, 2'd1, 0);
    step(0, 0, 4'b0011, 4'b0011, 4'b0001, 2'd0, 0);
    step(0, 0, 4'b0010, 4'b0011, 4'b0001, 2'd0, 0);

    // 5. wrap 3 -> 0, then sole requester 3 back-to-back, then idle
    step(0, 0, 4'b1000, 4'b0000, 4'b0010, 2'd1, 0);
    step(0, 0, 4'b1001, 4'b0000, 4'b1000, 2'd3, 0);
    step(0, 0, 4'b1000, 4'b0000, 4'b0001, 2'd0, 0);
    step(0, 0, 4'b1000, 4'b0000, 4'b1000, 2'd3, 0);
    step(0, 0, 4'b1000, 4'b0000, 4'b1000, 2'd3, 0);
    step(0, 0, 4'b0000, 4'b0000, 4'b1000, 2'd3, 0);
    step(0, 0, 4'b0000, 4'b0000, 4'b0000, 2'd3, 0);
    step(0, 1, 4'b0000, 4'b0000, 4'b0000, 2'd3, 0);

    // 6. unlimited hold (MAX_HOLD=0) and reset in the middle of a grant
    step(1, 0, 4'b0100, 4'b1111, 4'b0000, 2'd0, 0);
    for (int k = 0; k < 10; k++) begin
      step(1, 0, 4'b0100, 4'b1111, 4'b0100, 2'd2, 0);
    end
    step(1, 1, 4'b1111, 4'b1111, 4'b0100, 2'd2, 0);
    step(1, 0, 4'b1111, 4'b1111, 4'b0000, 2'd0, 0);
    step(1, 0, 4'b1111, 4'b1111, 4'b0001, 2'd0, 0);
    step(1, 0, 4'b1111, 4'b1111, 4'b0001, 2'd0, 0);

    // ---------------- report ----------------
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
